fetch_ctrl: RTL and testbench

//  Sequences the instruction memory for the single-issue core. Owns the PC, boot-loads program words into
//  the instruction RAM, and issues {pc, inst} to decode through a one-deep registered stage.

---
 rtl/core_pkg.sv | 12 +
 rtl/fetch_ctrl.sv | 115 +++++++++++
 tb/tb_fetch_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the single-issue core: fetch FSM states and ISA constants.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] HALT_OPCODE = 7'h7F;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0033;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, boot-loads the instruction RAM, issues {pc, inst} to decode
// through one registered stage, and handles stall, redirect, HALT detection and run-cycle counting.
import core_pkg::*;

module fetch_ctrl #(
  parameter int          DEPTH       = 32,
  parameter int          AW          = 5,
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter logic [6:0]  HALT_OPCODE = core_pkg::HALT_OPCODE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          load_valid,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic [AW-1:0] imem_raddr,
  input  logic [31:0]   imem_rdata,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          if_valid,
  output logic [31:0]   if_pc,
  output logic [31:0]   if_inst,
  output logic          halted,
  output logic          fault,
  output logic [31:0]   cycle_count
);
  localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        if_valid_nxt, halted_nxt, fault_nxt;
  logic [31:0] if_pc_nxt, if_inst_nxt, cnt_nxt;

  // Boot-load path is purely combinational; the RAM is only writable outside RUN.
  assign load_ready = (state != RUN);
  assign imem_we    = load_valid & load_ready;
  assign imem_waddr = load_addr;
  assign imem_wdata = load_data;
  assign imem_raddr = pc[AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_inst     <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_valid    <= if_valid_nxt;
      if_pc       <= if_pc_nxt;
      if_inst     <= if_inst_nxt;
      halted      <= halted_nxt;
      fault       <= fault_nxt;
      cycle_count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    if_valid_nxt = if_valid;
    if_pc_nxt    = if_pc;
    if_inst_nxt  = if_inst;
    halted_nxt   = halted;
    fault_nxt    = fault;
    cnt_nxt      = cycle_count;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          pc_nxt     = RESET_PC;
          halted_nxt = 1'b0;
          fault_nxt  = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = RUN;
        end
      end
      RUN: begin
        cnt_nxt = cycle_count + 32'd1;
        // Redirect wins over stall so a taken branch is never lost behind a held pipeline.
        if (redirect_valid) begin
          pc_nxt       = redirect_pc & ~32'h3;
          if_valid_nxt = 1'b0;
        end else if (stall) begin
          // hold everything
        end else if (pc >= PC_LIMIT) begin
          if_valid_nxt = 1'b0;
          fault_nxt    = 1'b1;
          halted_nxt   = 1'b1;
          state_nxt    = HALT;
        end else if (imem_rdata[6:0] == HALT_OPCODE) begin
          if_valid_nxt = 1'b0;
          halted_nxt   = 1'b1;
          state_nxt    = HALT;
        end else begin
          if_valid_nxt = 1'b1;
          if_pc_nxt    = pc;
          if_inst_nxt  = imem_rdata;
          pc_nxt       = pc + 32'd4;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural instruction RAM and hand-computed expectations.
module tb_fetch_ctrl;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n, start, load_valid, stall, redirect_valid;
  logic [AW-1:0] load_addr, imem_waddr, imem_raddr;
  logic [31:0]   load_data, imem_wdata, imem_rdata, redirect_pc;
  logic          load_ready, imem_we, if_valid, halted, fault;
  logic [31:0]   if_pc, if_inst, cycle_count;
  logic [31:0]   mem [32];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_we) mem[imem_waddr] <= imem_wdata;
  assign imem_rdata = mem[imem_raddr];

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_ready(load_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .halted(halted), .fault(fault), .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    load_valid = 1'b1;
    load_addr  = AW'(a);
    load_data  = d;
    step();
    load_valid = 1'b0;
  endtask

  function automatic logic [31:0] addi_w(input int i);
    return 32'h13 | (32'(i) << 20);
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    step(); step();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Basic program: addi, addi, sw, HALT.
    load_valid = 1'b1; load_addr = 5'd0; load_data = 32'h0010_0093;
    #1;
    chk("idle_imem_we", 32'(imem_we), 32'd1);
    chk("idle_wdata", imem_wdata, 32'h0010_0093);
    step(); load_valid = 1'b0;
    load(1, 32'h0020_0113);
    load(2, 32'h0020_a023);
    load(3, 32'h0000_007F);
    start = 1'b1; step(); start = 1'b0;
    chk("start_if_valid", 32'(if_valid), 32'd0);
    step();
    chk("p1_valid", 32'(if_valid), 32'd1);
    chk("p1_pc", if_pc, 32'h0);
    chk("p1_inst", if_inst, 32'h0010_0093);
    step();
    chk("p2_pc", if_pc, 32'h4);
    chk("p2_inst", if_inst, 32'h0020_0113);
    step();
    chk("p3_pc", if_pc, 32'h8);
    chk("p3_inst", if_inst, 32'h0020_a023);
    step();
    chk("halt_valid", 32'(if_valid), 32'd0);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_cycles", cycle_count, 32'd4);
    step();
    chk("halt_hold_valid", 32'(if_valid), 32'd0);
    chk("halt_hold_cycles", cycle_count, 32'd4);
    chk("halt_load_ready", 32'(load_ready), 32'd1);

    // Refill with non-HALT words, HALT at word 12.
    for (int i = 0; i < 32; i++) load(i, (i == 12) ? 32'h0000_007F : addi_w(i));
    start = 1'b1; step(); start = 1'b0;
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_cycles", cycle_count, 32'd0);
    step(); step();
    chk("s_pre_pc", if_pc, 32'h4);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", if_pc, 32'h4);
      chk("stall_inst", if_inst, addi_w(1));
      chk("stall_raddr", 32'(imem_raddr), 32'd2);
      chk("stall_valid", 32'(if_valid), 32'd1);
    end
    chk("stall_cycles", cycle_count, 32'd5);
    stall = 1'b0;
    step();
    chk("unstall_pc", if_pc, 32'h8);
    chk("unstall_cycles", cycle_count, 32'd6);

    // Redirect beats stall.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h14;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    chk("redir_flush", 32'(if_valid), 32'd0);
    step();
    chk("redir_pc", if_pc, 32'h14);
    chk("redir_inst", if_inst, addi_w(5));

    // Misaligned target is word-aligned.
    redirect_valid = 1'b1; redirect_pc = 32'h13;
    step();
    redirect_valid = 1'b0;
    chk("mis_flush", 32'(if_valid), 32'd0);
    step();
    chk("mis_pc", if_pc, 32'h10);

    // Redirect onto the HALT word, then redirect away in the same cycle it is read.
    redirect_valid = 1'b1; redirect_pc = 32'h30;
    step();
    chk("hw_raddr", 32'(imem_raddr), 32'd12);
    redirect_pc = 32'h4;
    step();
    redirect_valid = 1'b0;
    chk("hw_no_halt", 32'(halted), 32'd0);
    chk("hw_flush", 32'(if_valid), 32'd0);
    step();
    chk("hw_target_pc", if_pc, 32'h4);
    chk("hw_cycles", cycle_count, 32'd13);

    // Loads are refused while running.
    load_valid = 1'b1; load_addr = 5'd0; load_data = 32'hDEAD_BEEF;
    #1;
    chk("run_load_ready", 32'(load_ready), 32'd0);
    chk("run_imem_we", 32'(imem_we), 32'd0);
    step();
    load_valid = 1'b0;
    chk("run_mem_kept", mem[0], addi_w(0));

    // Reset mid-run.
    rst_n = 1'b0;
    step();
    chk("mr_valid", 32'(if_valid), 32'd0);
    chk("mr_pc", if_pc, 32'h0);
    chk("mr_inst", if_inst, 32'h0);
    chk("mr_cycles", cycle_count, 32'd0);
    chk("mr_load_ready", 32'(load_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Run off the end of the RAM.
    load(12, addi_w(12));
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("walk_pc", if_pc, 32'(i * 4));
    end
    chk("walk_last_inst", if_inst, addi_w(31));
    step();
    chk("oob_fault", 32'(fault), 32'd1);
    chk("oob_halted", 32'(halted), 32'd1);
    chk("oob_valid", 32'(if_valid), 32'd0);
    chk("oob_cycles", cycle_count, 32'd33);
    step();
    chk("oob_sticky", 32'(fault), 32'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_halted", 32'(halted), 32'd0);
    chk("clr_cycles", cycle_count, 32'd0);
    step();
    chk("clr_pc", if_pc, 32'h0);
    chk("clr_valid", 32'(if_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
